// File: rtl/softmax_max_sched.sv
// softmax_max_sched
// -----------------------------------------------------------------------------
// Two-pass scheduler for the softmax front end.
//   Pass 1 (LOAD): accepts one input vector, stores it in a local buffer and
//   forwards each beat straight through to the max detector.
//   Pass 2 (REPLAY): after the detector signals completion, replays the stored
//   vector downstream with the latched vector maximum attached.
//
// Handshakes: a beat moves on a channel in the cycle where valid and ready are
// both high at the rising clock edge. valid never depends on ready; while
// valid is high and ready is low, data/last are held stable.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   s_valid/s_data/s_last input element stream, s_ready back-pressure
//   md_reset_vec          per-vector reset to the max detector (high in IDLE)
//   md_valid/md_data/md_last  element stream to the detector (passthrough)
//   md_vec_done/md_xmax   detector completion pulse and its maximum
//   m_valid/m_data/m_last replay stream, m_ready from downstream
//   m_xmax                vector maximum, stable for the whole replay
//   busy                  high in any state other than IDLE
//   err_clr/err_overflow  sticky overflow flag (vector longer than MAX_LEN)
module softmax_max_sched #(
    parameter int DATA_W  = 16,
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              md_reset_vec,
    output logic              md_valid,
    output logic [DATA_W-1:0] md_data,
    output logic              md_last,
    input  logic              md_vec_done,
    input  logic [DATA_W-1:0] md_xmax,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [DATA_W-1:0] m_xmax,
    input  logic              m_ready,
    output logic              busy,
    input  logic              err_clr,
    output logic              err_overflow
);

    localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] LOAD     = 2'd1;
    localparam logic [1:0] WAIT_MAX = 2'd2;
    localparam logic [1:0] REPLAY   = 2'd3;

    localparam logic [LEN_W-1:0]  LAST_IDX = LEN_W'(MAX_LEN - 1);
    localparam logic [LEN_W-1:0]  ONE      = LEN_W'(1);
    // Most negative Q7.8 value: any real element is >= this.
    localparam logic [DATA_W-1:0] MIN_VAL  = {1'b1, {(DATA_W-1){1'b0}}};

    logic [1:0]        state;
    logic [LEN_W-1:0]  wr_cnt;
    logic [LEN_W-1:0]  rd_cnt;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] vec_buf [MAX_LEN];

    logic accept;
    logic rd_fire;
    logic ovf_set;

    assign s_ready      = (state == LOAD);
    assign accept       = s_valid & s_ready;
    assign md_reset_vec = (state == IDLE);
    assign md_valid     = accept;
    assign md_data      = s_data;
    // The buffer end forces a vector boundary even without s_last.
    assign md_last      = s_last | (wr_cnt == LAST_IDX);
    assign m_valid      = (state == REPLAY);
    assign m_data       = vec_buf[rd_cnt[ADDR_W-1:0]];
    assign m_last       = m_valid & (rd_cnt == (len - ONE));
    assign rd_fire      = m_valid & m_ready;
    assign busy         = (state != IDLE);
    assign ovf_set      = accept & (wr_cnt == LAST_IDX) & ~s_last;

    // Buffer has no reset: its contents are only read after being written.
    always_ff @(posedge clk) begin
        if (accept) begin
            vec_buf[wr_cnt[ADDR_W-1:0]] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            wr_cnt <= '0;
            rd_cnt <= '0;
            len    <= '0;
            m_xmax <= MIN_VAL;
        end else begin
            case (state)
                IDLE: begin
                    state <= LOAD;
                end
                LOAD: begin
                    if (accept) begin
                        if (md_last) begin
                            len    <= wr_cnt + ONE;
                            wr_cnt <= '0;
                            state  <= WAIT_MAX;
                        end else begin
                            wr_cnt <= wr_cnt + ONE;
                        end
                    end
                end
                WAIT_MAX: begin
                    if (md_vec_done) begin
                        m_xmax <= md_xmax;
                        state  <= REPLAY;
                    end
                end
                REPLAY: begin
                    if (rd_fire) begin
                        if (m_last) begin
                            rd_cnt <= '0;
                            state  <= IDLE;
                        end else begin
                            rd_cnt <= rd_cnt + ONE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Setting wins over clearing so an overflow in the clear cycle is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_overflow <= 1'b0;
        end else if (ovf_set) begin
            err_overflow <= 1'b1;
        end else if (err_clr) begin
            err_overflow <= 1'b0;
        end
    end

endmodule

// File: doc/softmax_max_sched.md
Name: softmax_max_sched

Overview:
- Two-pass scheduler for the softmax front end.
- Pass 1: accepts one input vector (Q7.8 signed), buffers it locally, and streams it into the max-detector datapath, which it sequences (per-vector reset, valid, last).
- Pass 2: once the detector reports vector completion, replays the buffered vector downstream with the latched maximum attached, for the subtract/exp stage.

Parameters:
- DATA_W, 16, element width (signed Q7.8)
- MAX_LEN, 64, maximum elements per vector (buffer depth)
- LEN_W, 7, counter width; must hold MAX_LEN

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  input element valid
- s_data  in  DATA_W  input element
- s_last  in  1  last element of vector
- s_ready  out  1  scheduler accepts input
- md_reset_vec  out  1  per-vector max reset to detector
- md_valid  out  1  element valid to detector
- md_data  out  DATA_W  element to detector
- md_last  out  1  last element to detector
- md_vec_done  in  1  detector completion pulse (one cycle after last element)
- md_xmax  in  DATA_W  detector running/final max
- m_valid  out  1  replay element valid
- m_data  out  DATA_W  replay element
- m_last  out  1  last replay element
- m_xmax  out  DATA_W  vector maximum, stable for the whole replay
- m_ready  in  1  downstream accepts
- busy  out  1  high in any state except IDLE
- err_clr  in  1  clears err_overflow
- err_overflow  out  1  sticky: vector exceeded MAX_LEN

Behaviour:
- Clock and reset: single clock clk; asynchronous active-low reset rst_n.
- Reset values:
  - state=IDLE, counters=0, m_xmax=16'h8000, err_overflow=0.
  - s_ready=0, m_valid=0, md_valid=0, busy=0.
  - md_reset_vec=1 (decoded from IDLE).
- FSM states: IDLE, LOAD, WAIT_MAX, REPLAY.
- IDLE:
  - md_reset_vec=1, s_ready=0; lasts exactly one cycle, then goes unconditionally to LOAD.
  - md_reset_vec is never asserted in the same cycle as md_valid.
- LOAD:
  - s_ready=1.
  - md_valid=s_valid&s_ready, md_data=s_data, md_last=s_last|(wr_cnt==MAX_LEN-1); all combinational, zero-latency passthrough.
  - On each accepted beat: buf[wr_cnt]<=s_data, wr_cnt++.
  - On an accepted beat with md_last=1: len<=wr_cnt+1, wr_cnt<=0, go to WAIT_MAX.
  - Overflow: if the forced last fires (wr_cnt==MAX_LEN-1) without s_last, set err_overflow. The vector is truncated to MAX_LEN, and subsequent beats form the next vector.
- WAIT_MAX:
  - s_ready=0, md_valid=0.
  - On md_vec_done: m_xmax<=md_xmax, go to REPLAY.
  - No timeout; the state holds indefinitely until md_vec_done.
- REPLAY:
  - m_valid=1, m_data=buf[rd_cnt] (asynchronous array read), m_last=(rd_cnt==len-1).
  - On m_valid&m_ready: rd_cnt++.
  - On last handshake: rd_cnt<=0, go to IDLE.
  - m_data, m_last and m_valid are held stable while m_ready=0.
- m_xmax updates only on the WAIT_MAX→REPLAY transition; it holds its value through IDLE/LOAD of the next vector.
- err_overflow:
  - Set has priority over err_clr when both occur in the same cycle.
  - err_clr otherwise clears it in one cycle.
- Input ports are ignored outside LOAD (s_ready=0).
- Single-element vector: len=1; m_last is asserted on the first replay beat.
- Timing for an N-element vector at full throughput, with LOAD entered at cycle 0:
  - Last beat accepted at cycle N-1, md_vec_done at cycle N.
  - REPLAY entered at cycle N+1; first m_valid at cycle N+1; last handshake at cycle 2N.
  - IDLE at cycle 2N+1; next LOAD at cycle 2N+2.
- Reset mid-operation (any state): immediate return to IDLE with reset values; buffer contents are don't-care.

Test Plan:
- Vector {0x0100, 0xFF00, 0x0280, 0x0040} with s_last on 4th, m_ready=1:
  - md_reset_vec is seen exactly one cycle before LOAD.
  - m_data replays the 4 values in order with m_last on the 4th.
  - m_xmax=0x0280 throughout.
- All-negative vector {0x8001, 0xFF00, 0xC000}: m_xmax=0xFF00; a following vector {0x0005} gives m_xmax=0x0005, proving the per-vector reset.
- Backpressure: m_ready toggled 1,0,0,1,... during a 5-element replay:
  - No element is dropped or duplicated.
  - Outputs hold while m_ready=0.
  - busy stays 1 until after the last handshake.
- Overflow: 70 beats with s_last only on the 70th (MAX_LEN=64):
  - md_last is forced on beat 64 and err_overflow=1.
  - 64 elements are replayed.
  - Beats 65-70 form a 6-element second vector.
  - err_clr then clears err_overflow.
- Single-element vector 0x7FFF: m_valid and m_last are asserted together on the first replay cycle; m_xmax=0x7FFF.
- Assert rst_n low in WAIT_MAX and again in REPLAY: outputs return to reset values immediately, and the next vector is processed correctly from IDLE.
